// File: rtl/qar_gpio_pkg.sv
// qar_gpio_pkg: shared constants for the qar GPIO bank.
//   - word offsets of the 16 mapped registers
//   - reset values for IRQ_RISE, IRQ_POL and DB_CYCLES
package qar_gpio_pkg;

  localparam logic [4:0] OFF_DIR        = 5'd0;
  localparam logic [4:0] OFF_OUT        = 5'd1;
  localparam logic [4:0] OFF_IN         = 5'd2;
  localparam logic [4:0] OFF_OUT_SET    = 5'd3;
  localparam logic [4:0] OFF_OUT_CLR    = 5'd4;
  localparam logic [4:0] OFF_OUT_TGL    = 5'd5;
  localparam logic [4:0] OFF_IRQ_EN     = 5'd6;
  localparam logic [4:0] OFF_IRQ_STATUS = 5'd7;
  localparam logic [4:0] OFF_IRQ_RISE   = 5'd8;
  localparam logic [4:0] OFF_IRQ_FALL   = 5'd9;
  localparam logic [4:0] OFF_IRQ_LVL    = 5'd10;
  localparam logic [4:0] OFF_IRQ_POL    = 5'd11;
  localparam logic [4:0] OFF_DB_EN      = 5'd12;
  localparam logic [4:0] OFF_DB_CYCLES  = 5'd13;
  localparam logic [4:0] OFF_ALT_SEL    = 5'd14;
  localparam logic [4:0] OFF_RAW_IN     = 5'd15;

  localparam logic [31:0] IRQ_RISE_RST = 32'hFFFF_FFFF;
  localparam logic [31:0] IRQ_POL_RST  = 32'hFFFF_FFFF;

  // DB_CYCLES reset: 32, or the largest value the counter width can hold.
  function automatic int db_cycles_rst(input int db_w);
    if (db_w >= 6) return 32;
    return (1 << db_w) - 1;
  endfunction

endpackage

// File: rtl/qar_gpio_pin_filter.sv
// qar_gpio_pin_filter: one pin's input path.
//   pin_in  : asynchronous pad input
//   dir     : 1 = pin is an output; filt then follows out_val
//   out_val : the pin's driven output value (loopback source)
//   db_en   : enable debounce
//   thr     : debounce threshold T (caller guarantees T >= 1)
//   sync    : synchroniser output (RAW_IN bit)
//   filt    : filtered value; filt_d is filt one cycle earlier
module qar_gpio_pin_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int DB_W        = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            pin_in,
  input  logic            dir,
  input  logic            out_val,
  input  logic            db_en,
  input  logic [DB_W-1:0] thr,
  output logic            sync,
  output logic            filt,
  output logic            filt_d
);

  localparam logic [DB_W-1:0] ONE = DB_W'(1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [DB_W-1:0]        cnt;

  assign sync = sync_q[SYNC_STAGES-1];

  // cnt holds the number of consecutive differing samples already seen,
  // so a differing sample with cnt >= T-1 is the T-th one and is accepted.
  // cnt stays below T, so it can never wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      cnt    <= '0;
      filt   <= 1'b0;
      filt_d <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pin_in};
      filt_d <= filt;
      if (dir) begin
        filt <= out_val;
        cnt  <= '0;
      end else if (!db_en || (sync == filt)) begin
        filt <= sync;
        cnt  <= '0;
      end else if (cnt >= (thr - ONE)) begin
        filt <= sync;
        cnt  <= '0;
      end else begin
        cnt  <= cnt + ONE;
      end
    end
  end

endmodule

// File: rtl/qar_gpio_bank.sv
// qar_gpio_bank: parametrised GPIO bank on the word-addressed peripheral bus.
//   clk, rst_n          : clock, asynchronous active-low reset
//   write_en, addr_word : single-cycle register write strobe and word offset
//   wdata               : write data
//   read_en, rdata      : combinational read; rdata = 0 unless read_en and mapped
//   gpio_in             : asynchronous pad inputs
//   alt_in              : alternate-function drive values (pins 0..NUM_ALT-1)
//   gpio_out, gpio_dir  : pad output value and direction (1 = output)
//   irq                 : OR of enabled interrupt status bits
module qar_gpio_bank
  import qar_gpio_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int NUM_ALT     = 2,
  parameter int SYNC_STAGES = 2,
  parameter int DB_W        = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               write_en,
  input  logic               read_en,
  input  logic [4:0]         addr_word,
  input  logic [31:0]        wdata,
  output logic [31:0]        rdata,
  input  logic [WIDTH-1:0]   gpio_in,
  input  logic [NUM_ALT-1:0] alt_in,
  output logic [WIDTH-1:0]   gpio_out,
  output logic [WIDTH-1:0]   gpio_dir,
  output logic               irq
);

  localparam int              DB_RST_I = db_cycles_rst(DB_W);
  localparam logic [DB_W-1:0] ONE      = DB_W'(1);

  logic [WIDTH-1:0]   dir_r, dir_d, out_r;
  logic [WIDTH-1:0]   irq_en, irq_stat, irq_rise, irq_fall, irq_lvl, irq_pol;
  logic [WIDTH-1:0]   db_en;
  logic [DB_W-1:0]    db_cyc, thr;
  logic [NUM_ALT-1:0] alt_sel;

  logic [WIDTH-1:0]   sync, filt, filt_d;
  logic [WIDTH-1:0]   wd, w1c, edge_ev, lvl_ev, events;

  assign wd  = wdata[WIDTH-1:0];
  assign w1c = (write_en && addr_word == OFF_IRQ_STATUS) ? wd : '0;
  assign thr = (db_cyc == '0) ? ONE : db_cyc;

  // Per-pin output mux and input filter.
  for (genvar i = 0; i < WIDTH; i++) begin : g_pin
    if (i < NUM_ALT) begin : g_alt
      assign gpio_out[i] = alt_sel[i] ? alt_in[i] : out_r[i];
    end else begin : g_plain
      assign gpio_out[i] = out_r[i];
    end

    qar_gpio_pin_filter #(
      .SYNC_STAGES (SYNC_STAGES),
      .DB_W        (DB_W)
    ) u_filt (
      .clk     (clk),
      .rst_n   (rst_n),
      .pin_in  (gpio_in[i]),
      .dir     (dir_r[i]),
      .out_val (gpio_out[i]),
      .db_en   (db_en[i]),
      .thr     (thr),
      .sync    (sync[i]),
      .filt    (filt[i]),
      .filt_d  (filt_d[i])
    );
  end

  // Edges need DIR=0 now and last cycle so the loopback value switching
  // in or out of filt does not look like a pad edge.
  assign edge_ev = ((filt & ~filt_d & irq_rise) | (~filt & filt_d & irq_fall))
                   & ~dir_r & ~dir_d;
  assign lvl_ev  = ~(filt ^ irq_pol) & ~dir_r;
  assign events  = (irq_lvl & lvl_ev) | (~irq_lvl & edge_ev);

  assign irq      = |(irq_en & irq_stat);
  assign gpio_dir = dir_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dir_r    <= '0;
      dir_d    <= '0;
      out_r    <= '0;
      irq_en   <= '0;
      irq_stat <= '0;
      irq_rise <= WIDTH'(IRQ_RISE_RST);
      irq_fall <= '0;
      irq_lvl  <= '0;
      irq_pol  <= WIDTH'(IRQ_POL_RST);
      db_en    <= '0;
      db_cyc   <= DB_W'(DB_RST_I);
      alt_sel  <= '0;
    end else begin
      dir_d    <= dir_r;
      // Events win over a same-cycle W1C of the same bit.
      irq_stat <= (irq_stat & ~w1c) | events;
      if (write_en) begin
        case (addr_word)
          OFF_DIR:       dir_r    <= wd;
          OFF_OUT:       out_r    <= wd;
          OFF_OUT_SET:   out_r    <= out_r | wd;
          OFF_OUT_CLR:   out_r    <= out_r & ~wd;
          OFF_OUT_TGL:   out_r    <= out_r ^ wd;
          OFF_IRQ_EN:    irq_en   <= wd;
          OFF_IRQ_RISE:  irq_rise <= wd;
          OFF_IRQ_FALL:  irq_fall <= wd;
          OFF_IRQ_LVL:   irq_lvl  <= wd;
          OFF_IRQ_POL:   irq_pol  <= wd;
          OFF_DB_EN:     db_en    <= wd;
          OFF_DB_CYCLES: db_cyc   <= wdata[DB_W-1:0];
          OFF_ALT_SEL:   alt_sel  <= wdata[NUM_ALT-1:0];
          default: ;
        endcase
      end
    end
  end

  // Read mux. IN shows the driven value for output pins.
  always_comb begin
    rdata = '0;
    if (read_en) begin
      case (addr_word)
        OFF_DIR:        rdata[WIDTH-1:0]   = dir_r;
        OFF_OUT:        rdata[WIDTH-1:0]   = out_r;
        OFF_IN:         rdata[WIDTH-1:0]   = (dir_r & gpio_out) | (~dir_r & filt);
        OFF_IRQ_EN:     rdata[WIDTH-1:0]   = irq_en;
        OFF_IRQ_STATUS: rdata[WIDTH-1:0]   = irq_stat;
        OFF_IRQ_RISE:   rdata[WIDTH-1:0]   = irq_rise;
        OFF_IRQ_FALL:   rdata[WIDTH-1:0]   = irq_fall;
        OFF_IRQ_LVL:    rdata[WIDTH-1:0]   = irq_lvl;
        OFF_IRQ_POL:    rdata[WIDTH-1:0]   = irq_pol;
        OFF_DB_EN:      rdata[WIDTH-1:0]   = db_en;
        OFF_DB_CYCLES:  rdata[DB_W-1:0]    = db_cyc;
        OFF_ALT_SEL:    rdata[NUM_ALT-1:0] = alt_sel;
        OFF_RAW_IN:     rdata[WIDTH-1:0]   = sync;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_qar_gpio_bank.sv
module tb_qar_gpio_bank;
  localparam int WIDTH = 32, NUM_ALT = 2, SYNC_STAGES = 2, DB_W = 16;

  logic               clk = 1'b0, rst_n = 1'b0;
  logic               write_en = 1'b0, read_en = 1'b0;
  logic [4:0]         addr_word = '0;
  logic [31:0]        wdata = '0, rdata;
  logic [WIDTH-1:0]   gpio_in = '0, gpio_out, gpio_dir;
  logic [NUM_ALT-1:0] alt_in = '0;
  logic               irq;

  always #5 clk = ~clk;

  qar_gpio_bank #(.WIDTH(WIDTH), .NUM_ALT(NUM_ALT), .SYNC_STAGES(SYNC_STAGES), .DB_W(DB_W)) dut (
    .clk(clk), .rst_n(rst_n), .write_en(write_en), .read_en(read_en), .addr_word(addr_word),
    .wdata(wdata), .rdata(rdata), .gpio_in(gpio_in), .alt_in(alt_in),
    .gpio_out(gpio_out), .gpio_dir(gpio_dir), .irq(irq));

  int checks = 0, failures = 0;

  // Behavioural model: registers as plain words, pad history as an array of
  // past gpio_in samples, debounce as a count of consecutive differing samples.
  logic [31:0] m_dir, m_out, m_en, m_stat, m_rise, m_fall, m_lvl, m_pol;
  logic [31:0] m_dben, m_dbc, m_alt, m_filt, m_filt_d, m_dir_d;
  logic [31:0] m_hist[SYNC_STAGES];
  int          m_cnt[WIDTH];

  logic [31:0] nxt_gin = '0;
  logic [1:0]  nxt_alt = '0;
  logic [31:0] cap_rdata, cap_out;
  logic        cap_irq;

  task automatic m_reset();
    m_dir = 0; m_out = 0; m_en = 0; m_stat = 0; m_rise = 32'hFFFF_FFFF; m_fall = 0;
    m_lvl = 0; m_pol = 32'hFFFF_FFFF; m_dben = 0; m_dbc = 32; m_alt = 0;
    m_filt = 0; m_filt_d = 0; m_dir_d = 0;
    for (int s = 0; s < SYNC_STAGES; s++) m_hist[s] = 0;
    for (int i = 0; i < WIDTH; i++) m_cnt[i] = 0;
  endtask

  function automatic logic [31:0] m_gout();
    return (m_out & ~m_alt) | ({30'b0, alt_in} & m_alt);
  endfunction

  function automatic logic [31:0] m_read();
    logic [31:0] g;
    g = m_gout();
    if (!read_en) return 0;
    case (addr_word)
      0: return m_dir;   1: return m_out;
      2: return (m_dir & g) | (~m_dir & m_filt);
      6: return m_en;    7: return m_stat;  8: return m_rise;  9: return m_fall;
      10: return m_lvl;  11: return m_pol;  12: return m_dben; 13: return m_dbc;
      14: return m_alt;  15: return m_hist[SYNC_STAGES-1];
      default: return 0;
    endcase
  endfunction

  task automatic m_step();
    logic [31:0] g, s, ev, nf;
    int t;
    g = m_gout();
    s = m_hist[SYNC_STAGES-1];
    t = (m_dbc == 0) ? 1 : int'(m_dbc);
    ev = 0; nf = m_filt;
    for (int i = 0; i < WIDTH; i++) begin
      if (m_dir[i]) ev[i] = 1'b0;
      else if (m_lvl[i]) ev[i] = (m_filt[i] == m_pol[i]);
      else if (m_dir_d[i]) ev[i] = 1'b0;
      else ev[i] = (m_rise[i] && m_filt[i] && !m_filt_d[i]) ||
                   (m_fall[i] && !m_filt[i] && m_filt_d[i]);
      if (m_dir[i]) begin nf[i] = g[i]; m_cnt[i] = 0; end
      else if (!m_dben[i] || s[i] == m_filt[i]) begin nf[i] = s[i]; m_cnt[i] = 0; end
      else begin
        m_cnt[i]++;
        if (m_cnt[i] >= t) begin nf[i] = s[i]; m_cnt[i] = 0; end
      end
    end
    for (int k = SYNC_STAGES-1; k > 0; k--) m_hist[k] = m_hist[k-1];
    m_hist[0] = gpio_in;
    m_stat = (m_stat & ~((write_en && addr_word == 7) ? wdata : 32'h0)) | ev;
    m_filt_d = m_filt; m_dir_d = m_dir; m_filt = nf;
    if (write_en) case (addr_word)
      0: m_dir = wdata;  1: m_out = wdata;  3: m_out = m_out | wdata;
      4: m_out = m_out & ~wdata;  5: m_out = m_out ^ wdata;
      6: m_en = wdata;   8: m_rise = wdata; 9: m_fall = wdata; 10: m_lvl = wdata;
      11: m_pol = wdata; 12: m_dben = wdata; 13: m_dbc = wdata & 32'hFFFF;
      14: m_alt = wdata & 32'h3;
      default: ;
    endcase
  endtask

  task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%h exp=%h", name, $time, got, exp);
    end
  endtask

  // One bus cycle: drive at negedge, compare against the model once settled,
  // then advance the model on the following posedge.
  task automatic cyc(input logic we, input logic re, input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    write_en = we; read_en = re; addr_word = a; wdata = d;
    gpio_in = nxt_gin; alt_in = nxt_alt;
    #1;
    cmp("rdata", rdata, m_read());
    cmp("irq", {31'b0, irq}, {31'b0, |(m_en & m_stat)});
    cmp("gpio_out", gpio_out, m_gout());
    cmp("gpio_dir", gpio_dir, m_dir);
    cap_rdata = rdata; cap_irq = irq; cap_out = gpio_out;
    @(posedge clk);
    m_step();
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 1'b0, 5'd0, 32'h0);
  endtask
  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    cyc(1'b1, 1'b0, a, d);
  endtask
  task automatic rd(input logic [4:0] a);
    cyc(1'b0, 1'b1, a, 32'h0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; write_en = 0; read_en = 0;
    m_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [31:0] exp;
    logic [31:0] d;
    logic [4:0]  a;
    m_reset();
    do_reset();

    // Reset readback of every mapped offset.
    for (int i = 0; i < 16; i++) begin
      rd(5'(i));
      exp = (i == 8 || i == 11) ? 32'hFFFF_FFFF : (i == 13) ? 32'd32 : 32'h0;
      cmp("reset_reg", cap_rdata, exp);
    end
    cmp("reset_irq", {31'b0, cap_irq}, 32'h0);
    cmp("reset_gpio_out", cap_out, 32'h0);

    // Atomic set/clear/toggle.
    wr(1, 32'hF0); wr(5, 32'hFF); rd(1); cmp("out_tgl", cap_rdata, 32'h0F);
    wr(3, 32'h1);  rd(1); cmp("out_set", cap_rdata, 32'h0F);
    wr(4, 32'hF0); rd(1); cmp("out_clr_f0", cap_rdata, 32'h0F);
    wr(4, 32'h0F); rd(1); cmp("out_clr_0f", cap_rdata, 32'h00);

    // Falling-edge interrupt latency on pin 0.
    nxt_gin = 32'h1; idle(4);
    wr(8, 32'h0); wr(9, 32'h1); wr(7, 32'hFFFF_FFFF); wr(6, 32'h1);
    rd(7); cmp("status_clear", cap_rdata, 32'h0);
    nxt_gin = 32'h0; idle(3);
    idle(1); cmp("irq_before_3", {31'b0, cap_irq}, 32'h0);
    idle(1); cmp("irq_at_3", {31'b0, cap_irq}, 32'h1);
    wr(7, 32'h1); idle(1); cmp("irq_w1c", {31'b0, cap_irq}, 32'h0);
    // W1C colliding with a new fall leaves the bit set.
    nxt_gin = 32'h1; idle(4);
    nxt_gin = 32'h0; idle(3); wr(7, 32'h1);
    rd(7); cmp("w1c_vs_event", cap_rdata, 32'h1);
    cmp("w1c_vs_event_irq", {31'b0, cap_irq}, 32'h1);
    wr(7, 32'h1);

    // Debounce on pin 3, T=5: 4-cycle glitch rejected, 5-cycle step accepted.
    wr(12, 32'h8); wr(13, 32'd5); wr(8, 32'h8); wr(7, 32'hFFFF_FFFF);
    for (int n = 0; n < 14; n++) begin
      nxt_gin = (n < 4) ? 32'h8 : 32'h0;
      rd(2); cmp("glitch_in", cap_rdata & 32'h8, 32'h0);
    end
    rd(7); cmp("glitch_status", cap_rdata, 32'h0);
    nxt_gin = 32'h8;
    for (int n = 0; n < 9; n++) begin
      if (n == 6)      begin rd(2); cmp("db_in_early", cap_rdata & 32'h8, 32'h0); end
      else if (n == 7) begin rd(2); cmp("db_in_set", cap_rdata & 32'h8, 32'h8); end
      else if (n == 8) begin rd(7); cmp("db_status", cap_rdata, 32'h8); end
      else idle(1);
    end
    wr(7, 32'hFFFF_FFFF);

    // Level mode, active-low on pin 2.
    wr(11, 32'hFFFF_FFFB); wr(10, 32'h4); idle(1);
    rd(7); cmp("lvl_set", cap_rdata & 32'h4, 32'h4);
    wr(7, 32'h4); rd(7); cmp("lvl_reset", cap_rdata & 32'h4, 32'h4);
    nxt_gin = 32'hC; idle(4);
    wr(7, 32'h4); rd(7); cmp("lvl_clear", cap_rdata & 32'h4, 32'h0);
    idle(2); rd(7); cmp("lvl_stays", cap_rdata & 32'h4, 32'h0);

    // Alternate function passthrough.
    wr(14, 32'h3);
    for (int n = 0; n < 4; n++) begin
      nxt_alt = 2'(n); idle(1);
      cmp("alt_out", cap_out & 32'h3, 32'(n));
    end
    // Direction change with OUT=1 raises no edge.
    wr(14, 32'h0); nxt_alt = 0; wr(8, 32'hFFFF_FFFF); wr(7, 32'hFFFF_FFFF);
    wr(1, 32'h1); wr(0, 32'h1); idle(4);
    rd(7); cmp("dir_no_edge", cap_rdata, 32'h0);
    wr(0, 32'h0);

    // Random phase, with one reset in the middle.
    for (int n = 0; n < 4000; n++) begin
      if (n == 2500) do_reset();
      nxt_gin = nxt_gin ^ ($urandom & $urandom & $urandom);
      nxt_alt = 2'($urandom);
      a = 5'($urandom_range(0, 17));
      d = $urandom;
      if (a == 0) d = $urandom & $urandom;
      if (a == 13 && $urandom_range(0, 9) != 0) d = $urandom_range(0, 6);
      if ($urandom_range(0, 2) == 0) cyc(1'b1, 1'($urandom), a, d);
      else cyc(1'b0, 1'($urandom), 5'($urandom), 32'h0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
